// File: rtl/pong_input_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : pong_input_sched_if
//  Description : Bundle between the hps_io side and the pong input scheduler.
//                The master modport is the control source, and the slave
//                modport is the scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
interface pong_input_sched_if;
    logic        vblank;
    logic [1:0]  mode_p1;
    logic [1:0]  mode_p2;
    logic [15:0] analog_p1;
    logic [15:0] analog_p2;
    logic [7:0]  paddle_p1;
    logic [7:0]  paddle_p2;
    logic        up_p1;
    logic        dn_p1;
    logic        up_p2;
    logic        dn_p2;
    logic        coin_req;
    logic [7:0]  paddle1_vpos;
    logic [7:0]  paddle2_vpos;
    logic        coin_sw;

    modport master (
        output vblank, mode_p1, mode_p2, analog_p1, analog_p2,
               paddle_p1, paddle_p2, up_p1, dn_p1, up_p2, dn_p2, coin_req,
        input  paddle1_vpos, paddle2_vpos, coin_sw
    );

    modport slave (
        input  vblank, mode_p1, mode_p2, analog_p1, analog_p2,
               paddle_p1, paddle_p2, up_p1, dn_p1, up_p2, dn_p2, coin_req,
        output paddle1_vpos, paddle2_vpos, coin_sw
    );
endinterface
`default_nettype wire

// File: rtl/pong_input_sched.sv
`default_nettype none
// ============================================================================
//  Module      : pong_input_sched
//  Description : Per-frame input scheduler. At VBLANK entry it walks P1, P2
//                and the coin stage. One shared slew-limited datapath serves
//                both paddles, and the coin switch pulse is counted in frames.
//  Revision    : 1.0  initial release
// ============================================================================
module pong_input_sched #(
    parameter int SLEW        = 8,
    parameter int DIG_STEP    = 4,
    parameter int COIN_FRAMES = 6
) (
    input  wire logic          clk_sys,
    input  wire logic          reset_n,
    pong_input_sched_if.slave  bus
);

    localparam logic [8:0] c_SLEW        = 9'(SLEW);
    localparam logic [7:0] c_DIG_STEP    = 8'(DIG_STEP);
    localparam logic [7:0] c_COIN_FRAMES = 8'(COIN_FRAMES);
    localparam logic [7:0] c_CENTER      = 8'h80;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        S_P1   = 2'd1,
        S_P2   = 2'd2,
        S_COIN = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_vblank_q;
    logic        r_coin_q;
    logic [7:0]  r_p1;
    logic [7:0]  r_p2;
    logic        r_coin_sw;
    logic [7:0]  r_coin_cnt;
    logic        r_coin_pend;

    logic        w_vb_edge;
    logic        w_coin_edge;
    logic        w_coin_accept;

    logic        w_sel_p2;
    logic [7:0]  w_cur;
    logic [1:0]  w_mode;
    logic [15:0] w_analog;
    logic [7:0]  w_paddle;
    logic        w_up;
    logic        w_dn;
    logic [7:0]  w_target;
    logic [8:0]  w_diff;
    logic [8:0]  w_abs;
    logic [7:0]  w_slewed;

    assign w_vb_edge   = bus.vblank & ~r_vblank_q;
    assign w_coin_edge = bus.coin_req & ~r_coin_q;

    // An edge arriving while a pulse is active or counting down is dropped.
    // An edge that lands in the same S_COIN cycle that starts the pulse
    // belongs to that pulse.
    assign w_coin_accept = w_coin_edge && (r_coin_cnt == 8'd0) && !r_coin_sw
                           && !((r_state == S_COIN) && r_coin_pend);

    // Delay registers for rising-edge detection on vblank and coin_req
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_vblank_q <= 1'b0;
            r_coin_q   <= 1'b0;
        end else begin
            r_vblank_q <= bus.vblank;
            r_coin_q   <= bus.coin_req;
        end
    end

    // State register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: leave IDLE only on VBLANK entry, then walk the stages once.
    // A vblank edge seen outside IDLE is not queued.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_vb_edge) w_next_state = S_P1;
            S_P1:    w_next_state = S_P2;
            S_P2:    w_next_state = S_COIN;
            S_COIN:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Shared operand mux: player 2 owns the datapath only in S_P2
    always_comb begin
        w_sel_p2 = (r_state == S_P2);
        w_cur    = w_sel_p2 ? r_p2          : r_p1;
        w_mode   = w_sel_p2 ? bus.mode_p2   : bus.mode_p1;
        w_analog = w_sel_p2 ? bus.analog_p2 : bus.analog_p1;
        w_paddle = w_sel_p2 ? bus.paddle_p2 : bus.paddle_p1;
        w_up     = w_sel_p2 ? bus.up_p2     : bus.up_p1;
        w_dn     = w_sel_p2 ? bus.dn_p2     : bus.dn_p1;
    end

    // Target selection: an analog source, or a digital step when exactly one
    // of up/dn is held
    always_comb begin
        w_target = w_paddle;
        case (w_mode)
            2'd0:    w_target = w_analog[15:8] + c_CENTER;
            2'd1:    w_target = w_analog[7:0]  + c_CENTER;
            2'd2:    w_target = w_analog[7:0]  ^ 8'h7F;
            default: w_target = w_paddle;
        endcase
        if (w_up && !w_dn) begin
            w_target = (w_cur < c_DIG_STEP) ? 8'h00 : (w_cur - c_DIG_STEP);
        end else if (w_dn && !w_up) begin
            w_target = (w_cur > (8'hFF - c_DIG_STEP)) ? 8'hFF : (w_cur + c_DIG_STEP);
        end
    end

    // Slew limiter. The signed 9-bit difference covers -255..255. A step of
    // SLEW is taken only when the target is farther away than SLEW, so the
    // result can never wrap.
    always_comb begin
        w_diff   = {1'b0, w_target} - {1'b0, w_cur};
        w_abs    = w_diff[8] ? (9'd0 - w_diff) : w_diff;
        w_slewed = w_target;
        if (w_abs > c_SLEW) begin
            w_slewed = w_diff[8] ? (w_cur - c_SLEW[7:0]) : (w_cur + c_SLEW[7:0]);
        end
    end

    // Paddle position registers: each one updates only in its own state
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_p1 <= c_CENTER;
            r_p2 <= c_CENTER;
        end else begin
            if (r_state == S_P1) r_p1 <= w_slewed;
            if (r_state == S_P2) r_p2 <= w_slewed;
        end
    end

    // Coin capture and frame-counted pulse: the pulse starts, counts down
    // and ends only in S_COIN
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_coin_sw   <= 1'b0;
            r_coin_cnt  <= 8'd0;
            r_coin_pend <= 1'b0;
        end else begin
            if (r_state == S_COIN) begin
                if (r_coin_pend) begin
                    r_coin_cnt  <= c_COIN_FRAMES;
                    r_coin_sw   <= 1'b1;
                    r_coin_pend <= 1'b0;
                end else if (r_coin_cnt > 8'd1) begin
                    r_coin_cnt <= r_coin_cnt - 8'd1;
                end else if (r_coin_cnt == 8'd1) begin
                    r_coin_cnt <= 8'd0;
                    r_coin_sw  <= 1'b0;
                end
            end
            if (w_coin_accept) r_coin_pend <= 1'b1;
        end
    end

    assign bus.paddle1_vpos = r_p1;
    assign bus.paddle2_vpos = r_p2;
    assign bus.coin_sw      = r_coin_sw;

endmodule
`default_nettype wire

// File: tb/tb_pong_input_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pong_input_sched
//  Description : Directed self-checking bench for pong_input_sched. Each frame
//                queues its expected outputs, and they are compared when the
//                DUT publishes them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pong_input_sched;

    logic clk = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    logic [7:0] sb_q[$];
    logic [7:0] m_p1;
    logic [7:0] m_p2;

    pong_input_sched_if bus ();

    pong_input_sched #(
        .SLEW        (8),
        .DIG_STEP    (4),
        .COIN_FRAMES (6)
    ) dut (
        .clk_sys (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_target(input logic [1:0] mode, input logic [15:0] an,
                                            input logic [7:0] pad, input logic up,
                                            input logic dn, input logic [7:0] cur);
        int t;
        case (mode)
            2'd0:    t = (int'(an[15:8]) + 128) % 256;
            2'd1:    t = (int'(an[7:0]) + 128) % 256;
            2'd2:    t = int'(an[7:0] ^ 8'h7F);
            default: t = int'(pad);
        endcase
        if (up && !dn) t = (int'(cur) - 4 < 0) ? 0 : int'(cur) - 4;
        if (dn && !up) t = (int'(cur) + 4 > 255) ? 255 : int'(cur) + 4;
        return 8'(t);
    endfunction

    function automatic logic [7:0] m_slew(input logic [7:0] cur, input logic [7:0] tgt);
        int d;
        d = int'(tgt) - int'(cur);
        if (d > 8)  return 8'(int'(cur) + 8);
        if (d < -8) return 8'(int'(cur) - 8);
        return tgt;
    endfunction

    task automatic sb_check(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=%h expected=queued_value", tag, obs);
        end else begin
            e = sb_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    // One frame: queue the expectations, raise vblank, then compare at
    // E+2 (paddle 1), E+3 (paddle 2) and E+4 (coin switch)
    task automatic frame(input logic exp_coin);
        m_p1 = m_slew(m_p1, m_target(bus.mode_p1, bus.analog_p1, bus.paddle_p1,
                                     bus.up_p1, bus.dn_p1, m_p1));
        m_p2 = m_slew(m_p2, m_target(bus.mode_p2, bus.analog_p2, bus.paddle_p2,
                                     bus.up_p2, bus.dn_p2, m_p2));
        sb_q.push_back(m_p1);
        sb_q.push_back(m_p2);
        sb_q.push_back({7'd0, exp_coin});
        @(posedge clk); #1 bus.vblank = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 sb_check("p1_vpos", bus.paddle1_vpos);
        @(posedge clk); #1 sb_check("p2_vpos", bus.paddle2_vpos);
        @(posedge clk); #1 sb_check("coin_sw", {7'd0, bus.coin_sw});
        bus.vblank = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic coin_pulse();
        @(posedge clk); #1 bus.coin_req = 1'b1;
        @(posedge clk); #1 bus.coin_req = 1'b0;
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.vblank    = 1'b0;
        bus.mode_p1   = 2'd3;
        bus.mode_p2   = 2'd3;
        bus.analog_p1 = 16'h0000;
        bus.analog_p2 = 16'h0000;
        bus.paddle_p1 = 8'h80;
        bus.paddle_p2 = 8'h80;
        bus.up_p1     = 1'b0;
        bus.dn_p1     = 1'b0;
        bus.up_p2     = 1'b0;
        bus.dn_p2     = 1'b0;
        bus.coin_req  = 1'b0;

        // T1: reset holds the outputs while vblank toggles
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1 bus.vblank = ~bus.vblank;
        end
        bus.vblank = 1'b0;
        #1;
        check("rst_p1", bus.paddle1_vpos, 8'h80);
        check("rst_p2", bus.paddle2_vpos, 8'h80);
        check("rst_coin", {7'd0, bus.coin_sw}, 8'h00);
        @(posedge clk); #1 reset_n = 1'b1;
        bus.paddle_p1 = 8'hFF;
        repeat (5) @(posedge clk);
        #1;
        check("hold_p1", bus.paddle1_vpos, 8'h80);
        check("hold_p2", bus.paddle2_vpos, 8'h80);
        check("hold_coin", {7'd0, bus.coin_sw}, 8'h00);
        m_p1 = 8'h80;
        m_p2 = 8'h80;

        // T2: slew from 80 toward FF
        for (int i = 0; i < 20; i++) frame(1'b0);
        check("t2_final", bus.paddle1_vpos, 8'hFF);

        // T3: each analog mode on player 2 with analog_p2 = 40C0
        bus.analog_p2 = 16'h40C0;
        bus.paddle_p2 = 8'hC2;
        for (int i = 0; i < 40 && m_p2 != 8'hC2; i++) frame(1'b0);
        bus.mode_p2 = 2'd0;
        frame(1'b0);
        check("t3_mode0", bus.paddle2_vpos, 8'hC0);
        bus.mode_p2   = 2'd3;
        bus.paddle_p2 = 8'h42;
        for (int i = 0; i < 40 && m_p2 != 8'h42; i++) frame(1'b0);
        bus.mode_p2 = 2'd1;
        frame(1'b0);
        check("t3_mode1", bus.paddle2_vpos, 8'h40);
        bus.mode_p2   = 2'd3;
        bus.paddle_p2 = 8'hBC;
        for (int i = 0; i < 40 && m_p2 != 8'hBC; i++) frame(1'b0);
        bus.mode_p2 = 2'd2;
        frame(1'b0);
        check("t3_mode2", bus.paddle2_vpos, 8'hBF);

        // T4: digital override saturates at 0; up and down together fall
        // back to the analog target
        bus.paddle_p1 = 8'h02;
        for (int i = 0; i < 64 && m_p1 != 8'h02; i++) frame(1'b0);
        check("t4_preset", bus.paddle1_vpos, 8'h02);
        bus.up_p1 = 1'b1;
        frame(1'b0);
        check("t4_up_sat", bus.paddle1_vpos, 8'h00);
        frame(1'b0);
        check("t4_up_hold", bus.paddle1_vpos, 8'h00);
        bus.dn_p1     = 1'b1;
        bus.paddle_p1 = 8'h05;
        frame(1'b0);
        check("t4_both", bus.paddle1_vpos, 8'h05);
        bus.up_p1 = 1'b0;
        bus.dn_p1 = 1'b0;

        // T5: a coin pulse gives six frames high, and a second pulse during
        // the window does not extend it
        coin_pulse();
        frame(1'b1);
        frame(1'b1);
        coin_pulse();
        for (int i = 0; i < 4; i++) frame(1'b1);
        frame(1'b0);
        frame(1'b0);

        // T6: asynchronous reset in S_P2 with a coin pending
        coin_pulse();
        @(posedge clk); #1 bus.vblank = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 reset_n = 1'b0;
        #1;
        check("t6_p1", bus.paddle1_vpos, 8'h80);
        check("t6_p2", bus.paddle2_vpos, 8'h80);
        check("t6_coin", {7'd0, bus.coin_sw}, 8'h00);
        bus.vblank = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        m_p1 = 8'h80;
        m_p2 = 8'h80;
        frame(1'b0);
        frame(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
